fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch sequencer on the consuming side of the program-counter register. It takes the current PC value and issues a word-read request to instruction memory over a req/ack handshake. It buffers the returned instruction toward decode under a valid/ready handshake, and drives the next-PC value plus a one-cycle write strobe back into the PC register. One instruction is in flight at a time; a bounded-wait watchdog flags memory that never acknowledges.

## Interface
- `ACK_TIMEOUT`, default 16: max cycles `mem_req` is held without `mem_ack` before retry; 1..255.
- `PC_LIMIT`, default 32'h0000_0005: wrap point, used only under `FETCH_WRAP_EN`.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `pc_in` in 32: current PC register value.
- `next_pc` out 32: value to load into the PC register.
- `pc_we` out 1: PC load strobe, one cycle per retired fetch.
- `mem_req` out 1: instruction-memory read request.
- `mem_addr` out 32: read address, registered.
- `mem_ack` in 1: memory acknowledge; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: instruction word.
- `instr` out 32: buffered instruction.
- `instr_valid` out 1: `instr` holds an unconsumed word.
- `instr_ready` in 1: decode accepts `instr`.
- `branch_taken` in 1: redirect request, sampled at accept.
- `branch_target` in 32: redirect address.
- `fetch_err` out 1: sticky error flag; cleared only by reset.

## Operation
- States: IDLE, REQ, HOLD, STALL.
- Reset values: state IDLE; `mem_req`=0, `mem_addr`=0, `instr`=0, `instr_valid`=0, `pc_we`=0, `next_pc`=0, `fetch_err`=0, timeout counter 0.
- IDLE: wait exactly one cycle, then go to REQ. On entry to REQ, latch `mem_addr`←`pc_in`.
- Misalignment: if `pc_in[1:0]`≠0 at REQ entry, do not raise `mem_req`, set `fetch_err`, and go to STALL.
- REQ: hold `mem_req`=1 and keep `mem_addr` stable until `mem_ack`. On ack, capture `instr`←`mem_rdata`, set `instr_valid`=1, drop `mem_req`, and go to HOLD.
- Timeout: the counter increments each REQ cycle without ack. When it reaches `ACK_TIMEOUT`, set `fetch_err`, drop `mem_req` for one cycle, clear the counter, and re-enter REQ with the same address.
- HOLD: when `instr_valid` and `instr_ready` are both high, pulse `pc_we`=1 for one cycle and clear `instr_valid`. Set `next_pc` = `branch_taken` ? `branch_target` : `pc_in`+4, computed modulo 2^32 with carry discarded. Then go to IDLE.
- HOLD without `instr_ready`: `instr` and `instr_valid` stay stable; no new request is issued.
- STALL: terminal state. All strobes are 0; only `rst_n` exits it.
- `mem_ack` outside REQ is ignored.
- `branch_taken` outside an accept cycle is ignored.
- `next_pc` is registered and updates only in the `pc_we` cycle; otherwise it holds its value.

## Timing
- Fetch latency: REQ entry to `instr_valid`=1 is N+1 cycles, where N is the memory ack delay; a zero-wait ack gives 1.
- Accept cycle: `pc_we` and `next_pc` are valid in the cycle after the accept edge. The PC register loads on the following edge.
- IDLE then waits one cycle so `pc_in` reflects the new value before REQ latches it.
- Zero-wait throughput is one instruction per 4 cycles.
- Async reset mid-request drops `mem_req` immediately. A late `mem_ack` after reset is ignored.
- Retry gap after a timeout is exactly one cycle with `mem_req`=0.

## Configuration
- `FETCH_WRAP_EN` defined: if the computed `next_pc` equals `PC_LIMIT`, drive 0 instead. This applies to both sequential and branch paths.
- `FETCH_WRAP_EN` undefined: `next_pc` passes through unmodified, and `PC_LIMIT` is unused.

## Test plan
- Reset release, `pc_in`=0, `mem_ack` returned 2 cycles after `mem_req`, `mem_rdata`=32'hDEADBEEF, `instr_ready`=1 -> `mem_addr`=0, `instr`=32'hDEADBEEF, one `pc_we` pulse with `next_pc`=4, `fetch_err`=0.
- `instr_ready` held low 5 cycles in HOLD -> `instr` and `instr_valid` stable, no `mem_req`, no `pc_we`. On raising `instr_ready`, exactly one `pc_we`.
- Accept with `branch_taken`=1 and `branch_target`=32'h0000_0100 -> `next_pc`=32'h100, and the next `mem_addr`=32'h100.
- `pc_in`=32'hFFFF_FFFC -> `next_pc`=0 via carry wrap. With `FETCH_WRAP_EN` and `pc_in`=1, `PC_LIMIT`=5 -> `next_pc`=0; without the macro -> 5.
- No `mem_ack` with `ACK_TIMEOUT`=4 -> `mem_req` high for 4 cycles, low for 1, then high again with the same address; `fetch_err`=1.
- `pc_in`=32'h2, or `rst_n` pulsed low during REQ -> first case: STALL with `fetch_err`=1 and no `mem_req`. Second case: all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer_if
//  Description : Bus bundle between the fetch sequencer and its neighbours:
//                PC register, instruction memory and the decode stage.
//                master = sequencer side, slave = environment side.
//  Revision    : 1.0  initial release
// ============================================================================
interface fetch_sequencer_if;
    logic [31:0] pc_in;
    logic [31:0] next_pc;
    logic        pc_we;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        fetch_err;

    modport master (
        input  pc_in, mem_ack, mem_rdata, instr_ready, branch_taken, branch_target,
        output next_pc, pc_we, mem_req, mem_addr, instr, instr_valid, fetch_err
    );

    modport slave (
        output pc_in, mem_ack, mem_rdata, instr_ready, branch_taken, branch_target,
        input  next_pc, pc_we, mem_req, mem_addr, instr, instr_valid, fetch_err
    );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Single-outstanding instruction fetch sequencer. Reads the
//                word at pc_in over a req/ack handshake, buffers it toward
//                decode under valid/ready, and strobes next_pc into the PC
//                register. A watchdog retries unacknowledged requests and
//                raises a sticky fetch_err.
//                Optional feature macro: FETCH_WRAP_EN (next_pc == PC_LIMIT
//                is replaced by 0).
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_sequencer #(
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter logic [31:0] PC_LIMIT    = 32'h0000_0005
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_STALL = 2'd3
    } state_t;

`ifdef FETCH_WRAP_EN
    localparam logic c_WRAP_EN = 1'b1;
`else
    localparam logic c_WRAP_EN = 1'b0;
`endif

    // Counter value on which the watchdog fires (counter starts at 0 per request)
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_mem_req;
    logic [31:0] r_mem_addr;
    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic        r_pc_we;
    logic [31:0] r_next_pc;
    logic        r_fetch_err;

    logic [31:0] w_seq_pc;
    logic [31:0] w_raw_pc;
    logic [31:0] w_next_pc;

    // Next-PC candidate: sequential (carry out discarded) or branch redirect,
    // optionally folded to zero at the wrap point.
    assign w_seq_pc  = bus.pc_in + 32'd4;
    assign w_raw_pc  = bus.branch_taken ? bus.branch_target : w_seq_pc;
    assign w_next_pc = (c_WRAP_EN && (w_raw_pc == PC_LIMIT)) ? 32'd0 : w_raw_pc;

    // Fetch FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= 8'd0;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= 32'd0;
            r_instr       <= 32'd0;
            r_instr_valid <= 1'b0;
            r_pc_we       <= 1'b0;
            r_next_pc     <= 32'd0;
            r_fetch_err   <= 1'b0;
        end else begin
            r_pc_we <= 1'b0;
            case (r_state)
                // The pc_we cycle is spent here too; the request goes out only
                // after the PC register has taken the new value.
                S_IDLE: begin
                    if (!r_pc_we) begin
                        r_mem_addr <= bus.pc_in;
                        r_cnt      <= 8'd0;
                        if (bus.pc_in[1:0] != 2'b00) begin
                            r_fetch_err <= 1'b1;
                            r_state     <= S_STALL;
                        end else begin
                            r_mem_req <= 1'b1;
                            r_state   <= S_REQ;
                        end
                    end
                end
                // mem_req low inside REQ is the one-cycle retry gap
                S_REQ: begin
                    if (r_mem_req) begin
                        if (bus.mem_ack) begin
                            r_instr       <= bus.mem_rdata;
                            r_instr_valid <= 1'b1;
                            r_mem_req     <= 1'b0;
                            r_cnt         <= 8'd0;
                            r_state       <= S_HOLD;
                        end else if (r_cnt == c_TIMEOUT_LAST) begin
                            r_fetch_err <= 1'b1;
                            r_mem_req   <= 1'b0;
                            r_cnt       <= 8'd0;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end else begin
                        r_mem_req <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_instr_valid && bus.instr_ready) begin
                        r_pc_we       <= 1'b1;
                        r_instr_valid <= 1'b0;
                        r_next_pc     <= w_next_pc;
                        r_state       <= S_IDLE;
                    end
                end
                S_STALL: begin
                    r_mem_req <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req     = r_mem_req;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.instr       = r_instr;
    assign bus.instr_valid = r_instr_valid;
    assign bus.pc_we       = r_pc_we;
    assign bus.next_pc     = r_next_pc;
    assign bus.fetch_err   = r_fetch_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Self-checking bench for fetch_sequencer. Directed scenarios
//                plus randomized fetches compared against a PC/flag model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int unsigned c_TIMEOUT = 4;
    localparam logic [31:0] c_LIMIT   = 32'h0000_0005;

    logic clk;
    logic rst_n;
    fetch_sequencer_if bus();

    fetch_sequencer #(
        .ACK_TIMEOUT (c_TIMEOUT),
        .PC_LIMIT    (c_LIMIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_vec;
    int          n_err;
    logic [31:0] m_pc;
    logic        m_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference rule for the PC update
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic bt,
                                               input logic [31:0] tgt);
        logic [33:0] sum;
        logic [31:0] v;
        sum = {2'b00, pc} + 34'd4;
        v   = bt ? tgt : sum[31:0];
`ifdef FETCH_WRAP_EN
        if (v == c_LIMIT) v = 32'd0;
`endif
        return v;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_req"},   32'(bus.mem_req), 32'd0);
        check({tag, "_addr"},  bus.mem_addr, 32'd0);
        check({tag, "_instr"}, bus.instr, 32'd0);
        check({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
        check({tag, "_pcwe"},  32'(bus.pc_we), 32'd0);
        check({tag, "_npc"},   bus.next_pc, 32'd0);
        check({tag, "_err"},   32'(bus.fetch_err), 32'd0);
    endtask

    task automatic apply_reset(input logic [31:0] pc);
        rst_n             = 1'b0;
        bus.pc_in         = pc;
        bus.mem_ack       = 1'b0;
        bus.mem_rdata     = 32'd0;
        bus.instr_ready   = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'd0;
        @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        m_pc  = pc;
        m_err = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int unsigned waited;
        waited = 0;
        while (bus.mem_req !== 1'b1 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check(tag, 32'(bus.mem_req), 32'd1);
    endtask

    // One complete fetch: request, ack after dly cycles, rdy_dly cycles of
    // backpressure, then accept with the given branch inputs.
    task automatic do_fetch(input logic [31:0] data, input int unsigned dly,
                            input int unsigned rdy_dly, input logic bt,
                            input logic [31:0] tgt, input bit ovr,
                            input logic [31:0] ovr_pc);
        logic [31:0] pc_acc;
        logic [31:0] exp;
        wait_req("req_raise");
        check("mem_addr", bus.mem_addr, m_pc);
        for (int i = 0; i < int'(dly); i++) begin
            check("req_wait", 32'(bus.mem_req), 32'd1);
            check("valid_early", 32'(bus.instr_valid), 32'd0);
            @(negedge clk);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = data;
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom();
        check("instr_valid", 32'(bus.instr_valid), 32'd1);
        check("instr", bus.instr, data);
        check("req_drop", 32'(bus.mem_req), 32'd0);
        for (int i = 0; i < int'(rdy_dly); i++) begin
            bus.branch_taken  = 1'($urandom_range(1, 0));
            bus.branch_target = $urandom();
            bus.mem_ack       = 1'($urandom_range(1, 0));
            @(negedge clk);
            check("hold_instr", bus.instr, data);
            check("hold_valid", 32'(bus.instr_valid), 32'd1);
            check("hold_req", 32'(bus.mem_req), 32'd0);
            check("hold_pcwe", 32'(bus.pc_we), 32'd0);
        end
        bus.mem_ack = 1'b0;
        if (ovr) bus.pc_in = ovr_pc;
        pc_acc            = ovr ? ovr_pc : m_pc;
        bus.instr_ready   = 1'b1;
        bus.branch_taken  = bt;
        bus.branch_target = tgt;
        @(negedge clk);
        bus.instr_ready   = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = $urandom();
        exp = model_next(pc_acc, bt, tgt);
        check("pc_we", 32'(bus.pc_we), 32'd1);
        check("next_pc", bus.next_pc, exp);
        check("valid_clr", 32'(bus.instr_valid), 32'd0);
        check("err_flag", 32'(bus.fetch_err), 32'(m_err));
        m_pc      = exp;
        bus.pc_in = exp;
        @(negedge clk);
        check("pc_we_pulse", 32'(bus.pc_we), 32'd0);
        check("next_pc_hold", bus.next_pc, exp);
        check("idle_req", 32'(bus.mem_req), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] addr;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        @(negedge clk);

        // Basic fetch from 0 with a two-cycle ack delay
        apply_reset(32'd0);
        do_fetch(32'hDEADBEEF, 2, 0, 1'b0, 32'd0, 1'b0, 32'd0);
        // Backpressure for five cycles
        do_fetch($urandom(), 0, 5, 1'b0, 32'd0, 1'b0, 32'd0);
        // Branch redirect, then a fetch from the target
        do_fetch($urandom(), 1, 0, 1'b1, 32'h0000_0100, 1'b0, 32'd0);
        // Redirect to the top word, then wrap through carry
        do_fetch($urandom(), 0, 0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0);
        do_fetch($urandom(), 0, 0, 1'b0, 32'd0, 1'b0, 32'd0);
        check("carry_wrap", m_pc, 32'd0);

        // Randomized fetch stream
        for (int k = 0; k < 10; k++) begin
            r = $urandom();
            do_fetch($urandom(), $urandom_range(2, 0), $urandom_range(3, 0),
                     1'($urandom_range(3, 0) == 0), r & 32'hFFFF_FFFC, 1'b0, 32'd0);
        end

        // PC register reads 1 at accept: next_pc lands on the wrap point
        do_fetch($urandom(), 0, 1, 1'b0, 32'd0, 1'b1, 32'h0000_0001);

        // Watchdog: no ack, two full timeout windows
        apply_reset(32'h0000_0080);
        wait_req("to_req_raise");
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < int'(c_TIMEOUT); i++) begin
                check("to_req_high", 32'(bus.mem_req), 32'd1);
                check("to_addr", bus.mem_addr, 32'h0000_0080);
                check("to_err", 32'(bus.fetch_err), 32'(m_err));
                @(negedge clk);
            end
            m_err = 1'b1;
            check("to_gap", 32'(bus.mem_req), 32'd0);
            check("to_err_set", 32'(bus.fetch_err), 32'd1);
            @(negedge clk);
        end
        do_fetch($urandom(), 0, 0, 1'b0, 32'd0, 1'b0, 32'd0);
        check("to_err_sticky", 32'(bus.fetch_err), 32'd1);

        // Misaligned PC: terminal stall
        apply_reset(32'h0000_0002);
        @(negedge clk);
        check("mis_err", 32'(bus.fetch_err), 32'd1);
        for (int i = 0; i < 5; i++) begin
            bus.mem_ack     = 1'($urandom_range(1, 0));
            bus.instr_ready = 1'b1;
            @(negedge clk);
            check("mis_req", 32'(bus.mem_req), 32'd0);
            check("mis_pcwe", 32'(bus.pc_we), 32'd0);
            check("mis_valid", 32'(bus.instr_valid), 32'd0);
            check("mis_err_hold", 32'(bus.fetch_err), 32'd1);
        end

        // Asynchronous reset in the middle of a request
        apply_reset(32'h0000_0040);
        do_fetch($urandom(), 0, 0, 1'b0, 32'd0, 1'b0, 32'd0);
        addr = m_pc;
        wait_req("ar_req_raise");
        #2;
        rst_n       = 1'b0;
        bus.mem_ack = 1'b1;
        #1;
        check_reset_values("async");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check("ar_late_ack", 32'(bus.instr_valid), 32'd0);
        check("ar_req", 32'(bus.mem_req), 32'd1);
        m_pc  = addr;
        m_err = 1'b0;
        do_fetch($urandom(), 1, 0, 1'b0, 32'd0, 1'b0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
